// File: rtl/cmd_sequencer.sv
// Command sequencer: accepts a 16-bit command, dispatches opcodes 1-6 to an
// executor with a timeout, and returns a one-byte ACK/NAK/TMO response.
module cmd_sequencer #(
  parameter int unsigned TIMEOUT = 1000,
  parameter logic [7:0]  ACK     = 8'hA5,
  parameter logic [7:0]  NAK     = 8'h5A,
  parameter logic [7:0]  TMO     = 8'hEE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd,
  input  logic        cmd_rdy,
  output logic        clr_cmd_rdy,
  input  logic        tx_done,
  output logic        trmt,
  output logic [7:0]  resp,
  output logic        exec_go,
  output logic [3:0]  exec_op,
  output logic [11:0] exec_arg,
  input  logic        exec_done,
  input  logic        exec_err,
  output logic        exec_abort,
  output logic        busy,
  output logic [7:0]  cmd_cnt,
  output logic [7:0]  err_cnt
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DECODE  = 3'd1,
    EXEC    = 3'd2,
    RESP    = 3'd3,
    WAIT_TX = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] tmo_cnt, tmo_cnt_nxt;
  logic          clr_nxt, go_nxt, abort_nxt, trmt_nxt, busy_nxt;
  logic [7:0]    resp_nxt;
  logic          err_inc_c;
  logic          op_exec_c;

  assign op_exec_c = (exec_op != 4'd0) && (exec_op <= 4'd6);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_rdy) state_nxt = DECODE;
      DECODE:  state_nxt = op_exec_c ? EXEC : RESP;
      EXEC:    if (exec_done || (tmo_cnt == '0)) state_nxt = RESP;
      RESP:    state_nxt = WAIT_TX;
      WAIT_TX: if (tx_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs; a completion in the expiry cycle beats the timeout
  always_comb begin
    clr_nxt     = 1'b0;
    go_nxt      = 1'b0;
    abort_nxt   = 1'b0;
    resp_nxt    = resp;
    err_inc_c   = 1'b0;
    tmo_cnt_nxt = tmo_cnt;
    case (state)
      IDLE: clr_nxt = cmd_rdy;
      DECODE: begin
        if (exec_op == 4'd0) begin
          resp_nxt = ACK;
        end else if (op_exec_c) begin
          go_nxt      = 1'b1;
          tmo_cnt_nxt = TMO_LOAD;
        end else begin
          resp_nxt  = NAK;
          err_inc_c = 1'b1;
        end
      end
      EXEC: begin
        if (exec_done) begin
          resp_nxt  = exec_err ? NAK : ACK;
          err_inc_c = exec_err;
        end else if (tmo_cnt == '0) begin
          abort_nxt = 1'b1;
          resp_nxt  = TMO;
          err_inc_c = 1'b1;
        end else begin
          tmo_cnt_nxt = tmo_cnt - TW'(1);
        end
      end
      default: ;
    endcase
    trmt_nxt = (state_nxt == RESP);
    busy_nxt = (state_nxt != IDLE);
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cmd_rdy <= 1'b0;
      exec_go     <= 1'b0;
      exec_abort  <= 1'b0;
      trmt        <= 1'b0;
      busy        <= 1'b0;
      resp        <= 8'h00;
      exec_op     <= 4'h0;
      exec_arg    <= 12'h000;
      cmd_cnt     <= 8'h00;
      err_cnt     <= 8'h00;
      tmo_cnt     <= '0;
    end else begin
      clr_cmd_rdy <= clr_nxt;
      exec_go     <= go_nxt;
      exec_abort  <= abort_nxt;
      trmt        <= trmt_nxt;
      busy        <= busy_nxt;
      resp        <= resp_nxt;
      tmo_cnt     <= tmo_cnt_nxt;
      if (clr_nxt) begin
        exec_op  <= cmd[15:12];
        exec_arg <= cmd[11:0];
        cmd_cnt  <= cmd_cnt + 8'd1;
      end
      if (err_inc_c && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule
